// File: rtl/wb_xfer_master.sv
// ----------------------------------------------------------------------------
// wb_xfer_master: single-outstanding valid/ready -> Wishbone pipelined master
// with bus timeout and status reporting. Optional retry: WB_XFER_RETRY_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_xfer_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_adr_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  input  logic [DATA_W-1:0]   req_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic [1:0]          rsp_sts_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i,
  input  logic                wb_stall_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_ERR = 2'b01;
  localparam logic [1:0] STS_TMO = 2'b10;
  localparam logic [1:0] STS_RTY = 2'b11;

  if (TIMEOUT < 2 || MAX_RETRY < 0) begin : g_param_check
    $error("wb_xfer_master: TIMEOUT must be >= 2 and MAX_RETRY >= 0");
  end

`ifdef WB_XFER_RETRY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STROBE  = 3'd1,
    WAIT    = 3'd2,
    RESP    = 3'd3,
    BACKOFF = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             on_bus;
  logic             done;
  logic             expired;
  logic             retry;
  logic [1:0]       sts_term;

  assign req_ready_o = (state == IDLE);

  always_comb begin
    on_bus   = (state == STROBE) || (state == WAIT);
    // A termination only counts once the strobe has actually been issued.
    done     = ((state == STROBE && !wb_stall_i) || state == WAIT) &&
               (wb_ack_i || wb_err_i || wb_rty_i);
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    expired  = on_bus && (cnt_inc == CNT_MAX) && !done;
    sts_term = wb_err_i ? STS_ERR : (wb_rty_i ? STS_RTY : STS_OK);
  end

`ifdef WB_XFER_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] retry_cnt;

  assign retry = done && !wb_err_i && wb_rty_i && (retry_cnt != RTY_W'(MAX_RETRY));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_cnt <= '0;
    end else if (state == IDLE && req_valid_i) begin
      retry_cnt <= '0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid_i) state_nxt = STROBE;
      end
      STROBE, WAIT: begin
`ifdef WB_XFER_RETRY_EN
        if (retry) state_nxt = BACKOFF;
        else
`endif
        if (done || expired) state_nxt = RESP;
        else if (state == STROBE && !wb_stall_i) state_nxt = WAIT;
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
`ifdef WB_XFER_RETRY_EN
      BACKOFF: state_nxt = STROBE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_sts_o   <= STS_OK;
      cnt         <= '0;
    end else begin
      wb_cyc_o    <= (state_nxt == STROBE) || (state_nxt == WAIT);
      wb_stb_o    <= (state_nxt == STROBE);
      rsp_valid_o <= (state_nxt == RESP);
      // Counter restarts whenever cyc rises, including after a backoff gap.
      cnt <= (on_bus && (state_nxt == STROBE || state_nxt == WAIT)) ? cnt_inc : '0;
      if (state == IDLE && req_valid_i) begin
        wb_we_o  <= req_we_i;
        wb_adr_o <= req_adr_i;
        wb_sel_o <= req_sel_i;
        wb_dat_o <= req_dat_i;
      end
      if (done && !retry) begin
        rsp_sts_o <= sts_term;
        rsp_dat_o <= (!wb_err_i && !wb_rty_i && !wb_we_o) ? wb_dat_i : '0;
      end else if (expired) begin
        rsp_sts_o <= STS_TMO;
        rsp_dat_o <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_xfer_master.sv
// Scoreboard bench for wb_xfer_master: directed transfers against a scripted
// Wishbone slave; responses are checked by an independent monitor.
`default_nettype none

module tb_wb_xfer_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_sts_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;

  always #5 clk = ~clk;

  wb_xfer_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_sts_o(rsp_sts_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sts;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  // Slave script: term 0=ack 1=err 2=rty 3=never 4=err+ack
  int          cfg_stall = 0, cfg_wait = 0, cfg_term = 0;
  logic [31:0] cfg_rdata = '0;
  int          cyc_total = 0, stall_total = 0, issue_total = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  always @(negedge clk) begin : slave
    static int  stall_left = 0;
    static int  wait_left  = 0;
    static bit  issued     = 0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
    wb_dat_i = cfg_rdata;
    if (!wb_cyc_o) begin
      issued = 0; stall_left = cfg_stall; wait_left = cfg_wait;
    end else begin
      cyc_total++;
      if (wb_stb_o && !issued) begin
        if (stall_left > 0) begin
          wb_stall_i = 1'b1; stall_left--; stall_total++;
        end else begin
          issued = 1; issue_total++;
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
          if (cfg_wait == 0) drive_term();
        end
      end else if (issued) begin
        wait_left--;
        if (wait_left == 0) drive_term();
      end
    end
  end

  task automatic drive_term();
    case (cfg_term)
      0: wb_ack_i = 1'b1;
      1: wb_err_i = 1'b1;
      2: wb_rty_i = 1'b1;
      4: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin : monitor
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_sts", 64'(rsp_sts_o), 64'(e.sts));
        check("rsp_dat", 64'(rsp_dat_o), 64'(e.dat));
        check("cyc_low_at_rsp", 64'(wb_cyc_o), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input int stall, input int wt, input int term,
                      input logic [31:0] rdata, input logic [1:0] ests,
                      input logic [31:0] edat, output int lat);
    exp_t e;
    cfg_stall = stall; cfg_wait = wt; cfg_term = term; cfg_rdata = rdata;
    e.sts = ests; e.dat = edat;
    sb_q.push_back(e);
    req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_dat_i = wdat;
    req_valid_i = 1'b1;
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("rsp_wait_bound", 64'(lat), 64'd0);
    if (rsp_ready_i) tick();
  endtask

  initial begin : stim
    int lat, c0, s0, i0;
    bit seen;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_sts_dat", 64'({rsp_sts_o, rsp_dat_o}), 64'd0);
    check("rst_wb_adr", 64'(wb_adr_o), 64'd0);
    tick();

    // Read, 3 stall cycles, ack at issue
    s0 = stall_total; i0 = issue_total;
    xfer(0, 32'h100, 4'hF, 32'h0, 3, 0, 0, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, lat);
    check("stall_cycles", 64'(stall_total - s0), 64'd3);
    check("issues_read", 64'(issue_total - i0), 64'd1);

    // Zero-wait write
    xfer(1, 32'h4, 4'hF, 32'h15, 0, 0, 0, 32'hFFFF_FFFF, 2'b00, 32'h0, lat);
    check("write_latency", 64'(lat), 64'd2);
    check("write_bus", {cap_we, 3'b0, cap_sel, cap_adr[23:0], cap_dat}, {1'b1, 3'b0, 4'hF, 24'h4, 32'h15});

    // Slave never terminates
    c0 = cyc_total;
    xfer(0, 32'h8, 4'hF, 32'h0, 0, 0, 3, 32'h55AA55AA, 2'b10, 32'h0, lat);
    check("timeout_cyc_cycles", 64'(cyc_total - c0), 64'(TMO));

    // Transfer after timeout, ack after two wait cycles
    xfer(0, 32'hC, 4'h3, 32'h0, 0, 2, 0, 32'h12345678, 2'b00, 32'h12345678, lat);
    check("after_tmo_latency", 64'(lat), 64'd4);

    // err and ack together
    xfer(0, 32'h10, 4'hF, 32'h0, 0, 1, 4, 32'hCAFEF00D, 2'b01, 32'h0, lat);

    // ack in the cycle the counter reaches TIMEOUT
    c0 = cyc_total;
    xfer(0, 32'h14, 4'hF, 32'h0, 0, TMO - 1, 0, 32'hA1B2C3D4, 2'b00, 32'hA1B2C3D4, lat);
    check("edge_ack_cyc_cycles", 64'(cyc_total - c0), 64'(TMO));

    // rty always
    i0 = issue_total;
    xfer(1, 32'h18, 4'h1, 32'h77, 0, 0, 2, 32'h0, 2'b11, 32'h0, lat);
`ifdef WB_XFER_RETRY_EN
    check("rty_issues", 64'(issue_total - i0), 64'd4);
`else
    check("rty_issues", 64'(issue_total - i0), 64'd1);
`endif

    // Response held while rsp_ready is low
    rsp_ready_i = 1'b0;
    xfer(0, 32'h1C, 4'hF, 32'h0, 1, 0, 0, 32'h0BADC0DE, 2'b00, 32'h0BADC0DE, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_rsp", {rsp_valid_o, req_ready_o, rsp_sts_o, rsp_dat_o},
            {1'b1, 1'b0, 2'b00, 32'h0BADC0DE});
    end
    @(posedge clk); #2;
    rsp_ready_i = 1'b1;
    tick();

    // Reset pulsed while waiting for a termination
    cfg_stall = 0; cfg_wait = 0; cfg_term = 3;
    req_we_i = 1'b0; req_adr_i = 32'h20; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_in_wait", {wb_cyc_o, wb_stb_o}, 64'b10);
    @(posedge clk); #2;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc_stb_valid", {wb_cyc_o, wb_stb_o, rsp_valid_o}, 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1;
    end
    check("rst_mid_no_rsp", 64'(seen), 64'd0);
    tick();

    // Normal transfer after the reset
    xfer(0, 32'h24, 4'hF, 32'h0, 0, 0, 0, 32'h600DF00D, 2'b00, 32'h600DF00D, lat);
    check("post_rst_latency", 64'(lat), 64'd2);

    repeat (3) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
